// File: rtl/ad7673_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : ad7673_sampler_if
// Purpose  : Bundles the AD7673 pins and the sample/status bus of
//            ad7673_sampler.
//            master = ADC side and system controls (testbench or board).
//            slave  = the sampler itself.
// Signals  : enable, err_clear, BUSY, AD7673_DATA[17:0] -> sampler
//            CNVST_N, sample_valid, sample_data[9:0],
//            timeout_err, overrun_err             <- sampler
// Revision : 1.0 - initial release
// ============================================================================
interface ad7673_sampler_if;
    logic        enable;
    logic        err_clear;
    logic        BUSY;
    logic [17:0] AD7673_DATA;
    logic        CNVST_N;
    logic        sample_valid;
    logic [9:0]  sample_data;
    logic        timeout_err;
    logic        overrun_err;

    modport master (
        output enable, err_clear, BUSY, AD7673_DATA,
        input  CNVST_N, sample_valid, sample_data, timeout_err, overrun_err
    );

    modport slave (
        input  enable, err_clear, BUSY, AD7673_DATA,
        output CNVST_N, sample_valid, sample_data, timeout_err, overrun_err
    );
endinterface
`default_nettype wire

// File: rtl/ad7673_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ad7673_sampler
// Purpose  : Paced conversion sequencer for the AD7673 18-bit ADC. Issues a
//            CNVST_N pulse every SAMPLE_INTERVAL_CLK clocks while enabled,
//            follows the BUSY handshake, and reduces each result to a
//            rounded, saturated 10-bit sample with a one-cycle strobe.
// Ports    : clk          - system clock
//            reset_n_clk  - asynchronous active-low reset
//            bus          - ad7673_sampler_if.slave (ADC pins, controls,
//                           sample output and sticky error flags)
// Revision : 1.0 - initial release
// ============================================================================
module ad7673_sampler #(
    parameter int SAMPLE_INTERVAL_CLK = 3000,
    parameter int CNVST_LOW_CLK       = 2,
    parameter int BUSY_TIMEOUT_CLK    = 255
) (
    input  wire logic       clk,
    input  wire logic       reset_n_clk,
    ad7673_sampler_if.slave bus
);

    localparam int INT_W    = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
    localparam int PH_W     = (CNVST_LOW_CLK > 1) ? $clog2(CNVST_LOW_CLK) : 1;
    localparam int TO_W_RAW = $clog2(BUSY_TIMEOUT_CLK + 1);
    localparam int TO_W     = (TO_W_RAW > 8) ? TO_W_RAW : 8;

    localparam logic [INT_W-1:0] C_INT_LAST = INT_W'(SAMPLE_INTERVAL_CLK - 1);
    localparam logic [PH_W-1:0]  C_PH_LOAD  = PH_W'(CNVST_LOW_CLK - 1);
    localparam logic [TO_W-1:0]  C_TO_LIMIT = TO_W'(BUSY_TIMEOUT_CLK);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PULSE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // BUSY synchronizer (BUSY is asynchronous to clk)
    // ------------------------------------------------------------------
    logic busy_meta_q;
    logic busy_s_q;

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= bus.BUSY;
            busy_s_q    <= busy_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Interval counter: parked at 0 while disabled so the first enabled
    // cycle is always a tick.
    // ------------------------------------------------------------------
    logic [INT_W-1:0] int_cnt_q;
    logic [INT_W-1:0] int_cnt_d;
    logic             w_tick;

    always_comb begin
        int_cnt_d = int_cnt_q;
        if (!bus.enable || (int_cnt_q == C_INT_LAST)) begin
            int_cnt_d = '0;
        end else begin
            int_cnt_d = int_cnt_q + 1'b1;
        end
    end

    assign w_tick = bus.enable && (int_cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            int_cnt_q <= '0;
        end else begin
            int_cnt_q <= int_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample reduction: top 10 bits rounded by bit 7, saturated at 1023.
    // ------------------------------------------------------------------
    logic [17:0] data_q;
    logic [10:0] w_sum;
    logic [9:0]  w_sample;
    logic        w_unused_lsbs;

    assign w_sum         = {1'b0, data_q[17:8]} + {10'd0, data_q[7]};
    assign w_sample      = w_sum[10] ? 10'h3FF : w_sum[9:0];
    assign w_unused_lsbs = ^data_q[6:0];

    // ------------------------------------------------------------------
    // Conversion sequencer with registered outputs
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [PH_W-1:0]  ph_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             cnvst_n_q;
    logic             sample_valid_q;
    logic [9:0]       sample_data_q;
    logic             timeout_err_q;
    logic             overrun_err_q;

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            state_q        <= S_IDLE;
            ph_cnt_q       <= '0;
            to_cnt_q       <= '0;
            data_q         <= '0;
            cnvst_n_q      <= 1'b1;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            timeout_err_q  <= 1'b0;
            overrun_err_q  <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;

            // Clear first so a same-cycle error event below wins.
            if (bus.err_clear) begin
                timeout_err_q <= 1'b0;
                overrun_err_q <= 1'b0;
            end

            // A tick while busy is dropped; the next conversion waits for
            // the following tick.
            if (w_tick && (state_q != S_IDLE)) begin
                overrun_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_tick) begin
                        state_q   <= S_PULSE;
                        cnvst_n_q <= 1'b0;
                        ph_cnt_q  <= C_PH_LOAD;
                    end
                end

                S_PULSE: begin
                    if (ph_cnt_q == '0) begin
                        cnvst_n_q <= 1'b1;
                        to_cnt_q  <= '0;
                        state_q   <= S_WAIT_HI;
                    end else begin
                        ph_cnt_q <= ph_cnt_q - 1'b1;
                    end
                end

                S_WAIT_HI: begin
                    if (busy_s_q) begin
                        to_cnt_q <= '0;
                        state_q  <= S_WAIT_LO;
                    end else if (to_cnt_q == C_TO_LIMIT) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                S_WAIT_LO: begin
                    if (!busy_s_q) begin
                        data_q  <= bus.AD7673_DATA;
                        state_q <= S_CAPTURE;
                    end else if (to_cnt_q == C_TO_LIMIT) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                S_CAPTURE: begin
                    sample_data_q  <= w_sample;
                    sample_valid_q <= 1'b1;
                    state_q        <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.CNVST_N      = cnvst_n_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_data  = sample_data_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.overrun_err  = overrun_err_q;

endmodule
`default_nettype wire

// File: doc/ad7673_sampler.md
# ad7673_sampler

Paced conversion sequencer for the AD7673 18-bit ADC, upstream of the recording buffer. Issues a CNVST_N pulse every SAMPLE_INTERVAL_CLK clocks while capture is enabled and tracks the ADC's BUSY handshake. Captures the conversion result and reduces it to a rounded, saturated 10-bit sample. Each sample is delivered as a one-cycle sample_valid strobe, which the recorder uses as its write enable.

## Interface
- SAMPLE_INTERVAL_CLK, 3000: clocks between conversion starts; legal range ≥ 16.
- CNVST_LOW_CLK, 2: width of the CNVST_N low pulse in clocks; legal range ≥ 1.
- BUSY_TIMEOUT_CLK, 255: maximum clocks to wait in either BUSY phase.

- clk  in  1  system clock.
- reset_n_clk  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = capture running; level, synchronous to clk.
- err_clear  in  1  one-cycle pulse; clears sticky error flags.
- BUSY  in  1  AD7673 BUSY, asynchronous to clk.
- AD7673_DATA  in  18  AD7673 parallel result, straight binary.
- CNVST_N  out  1  conversion start, active-low, registered.
- sample_valid  out  1  one-cycle strobe; sample_data is new.
- sample_data  out  10  rounded/saturated sample; holds between strobes.
- timeout_err  out  1  sticky; a BUSY phase exceeded BUSY_TIMEOUT_CLK.
- overrun_err  out  1  sticky; an interval tick arrived while a conversion was in progress.

## Operation
- Reset values: CNVST_N=1, sample_valid=0, sample_data=0, timeout_err=0, overrun_err=0, FSM=IDLE, interval counter=0, BUSY synchronizer=0.
- BUSY passes through a 2-flop synchronizer (busy_s); the FSM uses only busy_s.
- Interval counter:
  - Held at 0 while enable=0.
  - Otherwise counts 0..SAMPLE_INTERVAL_CLK-1 and wraps to 0.
  - tick = enable && counter==0, so the first tick is the first cycle enable is high.
- FSM states:
  - IDLE: on tick, go to PULSE, drive CNVST_N=0, load the phase counter.
  - PULSE: hold CNVST_N=0 for CNVST_LOW_CLK cycles total, then CNVST_N=1 and go to WAIT_HI.
  - WAIT_HI: wait for busy_s=1, then go to WAIT_LO. Timeout → timeout_err=1, go to IDLE, no sample.
  - WAIT_LO: wait for busy_s=0, then go to CAPTURE and register AD7673_DATA. Timeout → timeout_err=1, go to IDLE.
  - CAPTURE: compute sample, pulse sample_valid, go to IDLE.
- The timeout counter resets on entry to WAIT_HI and again on entry to WAIT_LO; it counts in 8 bits minimum. A timeout occurs when the count reaches BUSY_TIMEOUT_CLK.
- Arithmetic: sample = DATA[17:8] + DATA[7], computed 11 bits wide. If the result exceeds 1023, sample_data = 1023.
- A tick in any state other than IDLE sets overrun_err and is dropped. The next conversion waits for the next tick.
- enable falling mid-conversion: the conversion runs to completion and its sample is still delivered. The counter clears, so no further ticks occur.
- err_clear clears both sticky flags. If err_clear coincides with a new error event in the same cycle, the flag is set (set wins).
- Reset mid-conversion: all outputs return to reset values immediately. CNVST_N=1 is forced even mid-pulse.

## Timing
- Tick seen at edge T: CNVST_N low from edge T through edge T+CNVST_LOW_CLK, high after.
- Synchronizer delay: a BUSY edge is seen by the FSM 2 edges after it is first sampled.
- Capture: if BUSY is sampled low at edge E, then busy_s=0 at E+1 and AD7673_DATA is registered at E+2.
- sample_valid is high for exactly one cycle, from edge E+3, with sample_data updated at the same edge.
- AD7673_DATA must be stable from BUSY fall through E+2 (guaranteed by the ADC).
- Minimum period: SAMPLE_INTERVAL_CLK must cover CNVST_LOW_CLK + conversion time + 6 clocks, or overrun_err sets.

## Test plan
- Nominal: interval 3000, BUSY model high 1–40 clocks after CNVST_N fall, DATA=18'h2A5C0 → sample_valid every 3000 clocks, sample_data=10'h2A6, CNVST_N low exactly 2 cycles.
- Rounding/saturation: DATA=18'h3FF80 → 1023; DATA=18'h0007F → 0; DATA=18'h00080 → 1.
- Timeout: BUSY never rises → timeout_err=1 after 255 clocks in WAIT_HI, no sample_valid. err_clear → timeout_err=0. The next tick converts normally.
- Overrun: interval 16, BUSY high 30 clocks → overrun_err=1. Every conversion still yields exactly one sample_valid.
- enable dropped 1 clock after the tick → that sample is still delivered, then no CNVST_N activity. Re-enable → CNVST_N falls on the first enabled edge.
- Reset asserted during WAIT_LO → CNVST_N=1, sample_valid=0, flags=0. After release with enable=1, the first conversion starts on the first edge.
